// File: rtl/join_reduce_stage_pkg.sv
// Shared definitions for join_reduce_stage and its output FIFO: reduction
// mode encodings and the explicit pointer-wrap helper.
package join_reduce_stage_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_ADD = 2'd0;
    localparam logic [MODE_W-1:0] MODE_MIN = 2'd1;
    localparam logic [MODE_W-1:0] MODE_MAX = 2'd2;
    localparam logic [MODE_W-1:0] MODE_XOR = 2'd3;

    // Wraps explicitly so DEPTH need not be a power of two.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/join_reduce_stage_fifo.sv
// stage_fifo: DEPTH-entry FIFO with occupancy count, head always presented.
// The caller only pushes when there is room or a pop happens in the same cycle.
module stage_fifo
    import join_reduce_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Memory is cleared on reset so the head never reads as X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= PW'(ptr_wrap(32'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PW'(ptr_wrap(32'(rd_ptr), DEPTH));
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/join_reduce_stage.sv
// Joins N_CH operand channels through one-entry holds, folds them with a
// runtime-selected reduction and queues results in a stage_fifo.
// Optional: JOIN_REDUCE_SAT_EN makes ADD saturate and adds the sat_o port.
module join_reduce_stage
    import join_reduce_stage_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CH-1:0]              v_i,
    input  logic [N_CH*WIDTH-1:0]        data_i,
    output logic [N_CH-1:0]              stall_o,
    input  logic [MODE_W-1:0]            mode_i,
    output logic                         v_o,
    output logic [WIDTH-1:0]             data_o,
    input  logic                         stall_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef JOIN_REDUCE_SAT_EN
    ,
    output logic                         sat_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef JOIN_REDUCE_SAT_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    logic [WIDTH-1:0] hold [N_CH];
    logic [N_CH-1:0]  hold_full;
    logic [N_CH-1:0]  xfer;
    logic             pop;
    logic             fire;
    logic [WIDTH-1:0] result;
    logic [FW-1:0]    fifo_in;
    logic [FW-1:0]    fifo_head;
`ifdef JOIN_REDUCE_SAT_EN
    logic             res_sat;
    logic [WIDTH:0]   sum;
`endif

    assign pop     = v_o && !stall_i;
    assign fire    = (&hold_full) && ((count_o != FULL) || pop);
    assign stall_o = hold_full & {N_CH{~fire}};
    assign xfer    = v_i & ~stall_o;

    // A channel refilled in a fire cycle keeps its hold_full bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (xfer[i]) begin
                    hold[i]      <= data_i[i*WIDTH +: WIDTH];
                    hold_full[i] <= 1'b1;
                end else if (fire) begin
                    hold_full[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        result = hold[0];
`ifdef JOIN_REDUCE_SAT_EN
        res_sat = 1'b0;
        sum     = '0;
`endif
        for (int i = 1; i < N_CH; i++) begin
            case (mode_i)
                MODE_ADD: begin
`ifdef JOIN_REDUCE_SAT_EN
                    sum     = {1'b0, result} + {1'b0, hold[i]};
                    res_sat = res_sat | sum[WIDTH];
                    result  = sum[WIDTH-1:0];
`else
                    result = result + hold[i];
`endif
                end
                MODE_MIN: result = (hold[i] < result) ? hold[i] : result;
                MODE_MAX: result = (hold[i] > result) ? hold[i] : result;
                default:  result = result ^ hold[i];
            endcase
        end
`ifdef JOIN_REDUCE_SAT_EN
        if (res_sat) begin
            result = '1;
        end
`endif
    end

`ifdef JOIN_REDUCE_SAT_EN
    assign fifo_in = {res_sat, result};
    assign sat_o   = v_o & fifo_head[WIDTH];
`else
    assign fifo_in = result;
`endif

    stage_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (count_o)
    );

    assign v_o    = (count_o != '0);
    assign data_o = fifo_head[WIDTH-1:0];

endmodule

// File: tb/tb_join_reduce_stage.sv
// Bench for join_reduce_stage: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the join/reduce/FIFO rules.
module tb_join_reduce_stage;
    import join_reduce_stage_pkg::*;

    localparam int N_CH  = 2;
    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam longint unsigned MASK = 64'hFFFF_FFFF;
`ifdef JOIN_REDUCE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       v_i;
    logic [N_CH*WIDTH-1:0] data_i;
    logic [N_CH-1:0]       stall_o;
    logic [1:0]            mode_i;
    logic                  v_o;
    logic [WIDTH-1:0]      data_o;
    logic                  stall_i;
    logic [CW-1:0]         count_o;
`ifdef JOIN_REDUCE_SAT_EN
    logic                  sat_o;
`endif

    always #5 clk = ~clk;

    join_reduce_stage #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .v_i     (v_i),
        .data_i  (data_i),
        .stall_o (stall_o),
        .mode_i  (mode_i),
        .v_o     (v_o),
        .data_o  (data_o),
        .stall_i (stall_i),
        .count_o (count_o)
`ifdef JOIN_REDUCE_SAT_EN
        ,
        .sat_o   (sat_o)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               s;
    } ent_t;

    logic [WIDTH-1:0] m_hold [N_CH];
    bit [N_CH-1:0]    m_hf = '0;
    ent_t             m_q[$];
    logic [WIDTH-1:0] got[$];
    logic [N_CH-1:0]  xfer = '0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model_reduce(input logic [1:0] mode);
        longint unsigned acc;
        longint unsigned x;
        bit ovf;
        ent_t e;
        acc = 64'(m_hold[0]);
        ovf = 1'b0;
        for (int i = 1; i < N_CH; i++) begin
            x = 64'(m_hold[i]);
            case (mode)
                MODE_ADD: begin
                    acc = acc + x;
                    if (acc > MASK) begin
                        ovf = 1'b1;
                        acc = acc & MASK;
                    end
                end
                MODE_MIN: if (x < acc) acc = x;
                MODE_MAX: if (x > acc) acc = x;
                default:  acc = acc ^ x;
            endcase
        end
        e.s = SAT_ON && (mode == MODE_ADD) && ovf;
        e.d = e.s ? WIDTH'(MASK) : WIDTH'(acc);
        return e;
    endfunction

    // One clock: compare DUT against model predictions, advance model, clock.
    task automatic cycle(input string tag);
        int cnt;
        bit pop;
        bit fire;
        logic [N_CH-1:0] exp_stall;
        ent_t r;
        #1;
        cnt       = m_q.size();
        pop       = (cnt != 0) && !stall_i;
        fire      = (&m_hf) && ((cnt < DEPTH) || pop);
        exp_stall = fire ? '0 : m_hf;
        check({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
        check({tag, ".v_o"}, 64'(v_o), 64'(cnt != 0));
        check({tag, ".count"}, 64'(count_o), 64'(cnt));
        if (cnt != 0) check({tag, ".data"}, 64'(data_o), 64'(m_q[0].d));
        else          check({tag, ".data_x"}, 64'($isunknown(data_o)), 64'(0));
`ifdef JOIN_REDUCE_SAT_EN
        check({tag, ".sat"}, 64'(sat_o), 64'((cnt != 0) ? m_q[0].s : 1'b0));
`endif
        if (reset) begin
            xfer = '0;
            m_q.delete();
            m_hf = '0;
        end else begin
            xfer = v_i & ~exp_stall;
            if (pop) got.push_back(data_o);
            r = model_reduce(mode_i);
            if (pop) void'(m_q.pop_front());
            if (fire) m_q.push_back(r);
            for (int i = 0; i < N_CH; i++) begin
                if (xfer[i]) begin
                    m_hold[i] = data_i[i*WIDTH +: WIDTH];
                    m_hf[i]   = 1'b1;
                end else if (fire) begin
                    m_hf[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        logic [N_CH-1:0] pend;
        int n;
        pend   = '1;
        n      = 0;
        data_i = {b, a};
        while (pend != '0 && n < 20) begin
            v_i = pend;
            cycle(tag);
            pend = pend & ~xfer;
            n++;
        end
        v_i = '0;
        check({tag, ".sent"}, 64'(pend), 64'(0));
    endtask

    task automatic expect_now(input string tag, input logic v, input logic [WIDTH-1:0] d,
                              input logic [CW-1:0] c);
        #1;
        check({tag, ".v_o"}, 64'(v_o), 64'(v));
        if (v) check({tag, ".data"}, 64'(data_o), 64'(d));
        check({tag, ".count"}, 64'(count_o), 64'(c));
    endtask

    task automatic run_one(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                           input bit exp_sat, input string tag);
        mode_i = mode;
        send(a, b, tag);
        cycle(tag);
        expect_now({tag, ".out"}, 1'b1, exp, CW'(1));
`ifdef JOIN_REDUCE_SAT_EN
        check({tag, ".sat_o"}, 64'(sat_o), 64'(exp_sat));
`else
        check({tag, ".no_sat"}, 64'(exp_sat), 64'(0));
`endif
        cycle(tag);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return WIDTH'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        v_i     = '0;
        data_i  = '0;
        mode_i  = MODE_ADD;
        stall_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst.v_o", 64'(v_o), 64'(0));
        check("rst.count", 64'(count_o), 64'(0));
        check("rst.stall", 64'(stall_o), 64'(0));
        check("rst.data", 64'(data_o), 64'(0));

        // Basic add with nominal latency
        send(32'd15, 32'd15, "t1");
        #1 check("t1.stall_after", 64'(stall_o), 64'(0));
        cycle("t1");
        expect_now("t1.res", 1'b1, 32'd30, CW'(1));
        cycle("t1");

        // Staggered arrival
        data_i = {32'd0, 32'd100};
        v_i    = 2'b01;
        cycle("t2");
        v_i = '0;
        #1 check("t2.stall_ch0", 64'(stall_o), 64'(2'b01));
        cycle("t2");
        data_i = {32'd10, 32'd100};
        v_i    = 2'b10;
        #1 check("t2.ch1_free", 64'(stall_o), 64'(2'b01));
        cycle("t2");
        v_i = '0;
        cycle("t2");
        expect_now("t2.res", 1'b1, 32'd110, CW'(1));
        cycle("t2");

        // Backpressure then release: outputs back to back in order
        stall_i = 1'b1;
        for (int k = 1; k <= 4; k++) send(WIDTH'(k), WIDTH'(k), "t3");
        cycle("t3");
        #1;
        check("t3.full_count", 64'(count_o), 64'(DEPTH));
        check("t3.full_stall", 64'(stall_o), 64'(2'b11));
        got.delete();
        stall_i = 1'b0;
        repeat (4) cycle("t3");
        check("t3.n_out", 64'(got.size()), 64'(4));
        for (int k = 0; k < 4 && k < got.size(); k++)
            check("t3.order", 64'(got[k]), 64'(2 * (k + 1)));
        #1 check("t3.drained", 64'(v_o), 64'(0));

        // Reduction modes
        run_one(MODE_MIN, 32'd7, 32'd3, 32'd3, 1'b0, "t4.min");
        run_one(MODE_MAX, 32'd7, 32'd3, 32'd7, 1'b0, "t4.max");
        run_one(MODE_XOR, 32'd7, 32'd3, 32'd4, 1'b0, "t4.xor");
        run_one(MODE_ADD, 32'hFFFF_FFFF, 32'd2, SAT_ON ? 32'hFFFF_FFFF : 32'd1, SAT_ON, "t4.ovf");

        // Mid-operation reset
        stall_i = 1'b1;
        mode_i  = MODE_ADD;
        send(32'd1, 32'd1, "t5");
        send(32'd2, 32'd2, "t5");
        cycle("t5");
        #1 check("t5.queued", 64'(count_o), 64'(2));
        data_i = {32'd0, 32'd9};
        v_i    = 2'b01;
        cycle("t5");
        reset  = 1'b1;
        data_i = {32'd77, 32'd0};
        v_i    = 2'b10;
        cycle("t5.rst");
        reset   = 1'b0;
        v_i     = '0;
        stall_i = 1'b0;
        #1;
        check("t5.v_o", 64'(v_o), 64'(0));
        check("t5.count", 64'(count_o), 64'(0));
        check("t5.stall", 64'(stall_o), 64'(0));
        run_one(MODE_ADD, 32'd5, 32'd6, 32'd11, 1'b0, "t5.after");

        // Full FIFO with simultaneous fire and pop, pointers wrap
        got.delete();
        stall_i = 1'b1;
        for (int k = 1; k <= 4; k++) send(WIDTH'(k), 32'd100, "t6");
        stall_i = 1'b0;
        for (int k = 5; k <= 11; k++) begin
            data_i = {32'd100, WIDTH'(k)};
            v_i    = 2'b11;
            #1 check("t6.count_full", 64'(count_o), 64'(DEPTH));
            cycle("t6");
            check("t6.xfer", 64'(xfer), 64'(2'b11));
        end
        v_i = '0;
        repeat (6) cycle("t6");
        check("t6.n_out", 64'(got.size()), 64'(11));
        for (int k = 0; k < 11 && k < got.size(); k++)
            check("t6.order", 64'(got[k]), 64'(101 + k));

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!(v_i[i] && !xfer[i])) begin
                    v_i[i] = ($urandom_range(0, 3) != 0);
                    data_i[i*WIDTH +: WIDTH] = pick();
                end
            end
            stall_i = ($urandom_range(0, 2) == 0);
            mode_i  = 2'($urandom_range(0, 3));
            reset   = ($urandom_range(0, 60) == 0);
            cycle("rand");
        end
        reset   = 1'b0;
        v_i     = '0;
        stall_i = 1'b0;
        repeat (8) cycle("drain");
        #1 check("end.empty", 64'(v_o), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/join_reduce_stage.md
Name: join_reduce_stage

Overview:
- Parametrised successor to the two-operand add stage in the valid/stall pipeline.
- Joins N_CH independent upstream channels. Each channel has a one-entry holding register, so channels may arrive in different cycles.
- Once every channel holds an operand, applies a runtime-selected reduction (add/min/max/xor) and pushes the result into a DEPTH-entry output FIFO.
- Sits between operand stages and a result stage. The output FIFO absorbs downstream stall so it does not reach upstream immediately.

Parameters:
- N_CH, 2, number of input channels (>=2)
- WIDTH, 32, operand and result width
- DEPTH, 2, output FIFO entries (>=1; need not be a power of two)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- v_i  in  N_CH  per-channel input valid
- data_i  in  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- stall_o  out  N_CH  per-channel stall to upstream; upstream holds data while set
- mode_i  in  2  0=ADD, 1=MIN (unsigned), 2=MAX (unsigned), 3=XOR; sampled on fire
- v_o  out  1  output valid
- data_o  out  WIDTH  FIFO head
- stall_i  in  1  downstream stall
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Input transfer on channel i: v_i[i] && !stall_o[i]. Data is captured into hold[i] at the clock edge and hold_full[i] is set.
- Output transfer (pop): v_o && !stall_i.
- fire = (&hold_full) && (count<DEPTH || pop).
- On fire:
  - the result is written to the FIFO tail;
  - all hold_full bits clear, unless the same channel transfers in that cycle, in which case hold_full stays set with the new data.
- stall_o[i] = hold_full[i] && !fire. This is combinational from stall_i through pop, which is permitted.
- Throughput: one result per cycle when unstalled.
- Latency: all channels transferring at edge t gives v_o=1 with the result in the cycle after edge t+1.
- Reduction is a left fold over channels 0..N_CH-1:
  - ADD wraps modulo 2^WIDTH;
  - MIN/MAX are unsigned compares;
  - XOR is bitwise.
- FIFO:
  - rd/wr pointers wrap explicitly from DEPTH-1 to 0;
  - count updates as +fire -pop, so simultaneous fire and pop leaves count unchanged, including when full;
  - v_o = (count!=0);
  - data_o = mem[rd_ptr]. When v_o=0, data_o is don't-care but must not be X after reset (memory cleared).
- Ordering: strict FIFO order; no result lost or duplicated under any stall pattern.
- Reset values: v_o=0, count_o=0, stall_o=0, data_o=0, holds empty, pointers 0.
- Reset asserted mid-operation discards all held operands and queued results in that cycle. Inputs presented during reset are not captured.
- No invalid states; mode_i is only meaningful in fire cycles.

Optional Feature:
- Macro: JOIN_REDUCE_SAT_EN.
- Defined: ADD saturates; if any partial sum exceeds 2^WIDTH-1, the result is all-ones. Adds output sat_o (1 bit, registered alongside each FIFO entry; it reads as the head entry's flag and is 0 when empty or after reset).
- Undefined: ADD wraps and the sat_o port is absent.
- Other modes are unaffected either way.

Decomposition:
- Shared package/header holds:
  - mode encodings (MODE_ADD, MODE_MIN, MODE_MAX, MODE_XOR);
  - mode width constant;
  - pointer-wrap helper.
- One natural sub-module, stage_fifo (parametrised WIDTH/DEPTH, push/pop/count). It is reusable by later stages.
- Reduction fold and holding registers are inline.

Test Plan:
1. N_CH=2, ADD, both channels v_i=1 with data 15 and 15 at edge t -> v_o=1, data_o=30, count_o=1 after edge t+1; stall_o stays 00.
2. Staggered arrival: ch0=100 at t, ch1=10 at t+2 -> stall_o[0]=1 through cycle t+2, fire at t+3, data_o=110 valid after t+3; ch1 is never stalled.
3. Backpressure, DEPTH=2, stall_i=1, send pairs (1,1),(2,2),(3,3),(4,4) -> count_o=2 and holds carry 3s; stall_o=11 until release; after stall_i=0, outputs 2,4,6,8 in order with no gaps once streaming.
4. Modes with 7 and 3 -> MIN 3, MAX 7, XOR 4. ADD 0xFFFFFFFF+2 -> 0x00000001 without the macro; 0xFFFFFFFF with sat_o=1 when JOIN_REDUCE_SAT_EN is defined.
5. Reset with 2 queued results and ch0 held -> next cycle v_o=0, count_o=0, stall_o=00; then 5+6 -> 11 with nominal latency.
6. DEPTH=3, full FIFO with continuous fire and pop for 7 transfers -> count_o stays 3, pointers wrap, output sequence matches input sequence exactly.
